// File: rtl/disp_bcd_counter.sv
// 8-digit BCD up/down counter feeding the seven-segment scan path.
// Prescaled stepping, clamped load, registered digit read port with blanking.
module disp_bcd_counter #(
   parameter int PRESCALE   = 100000000,
   parameter int PRESCALE_W = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        up,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        blank_lz,
   input  logic [2:0]  scan_idx,
   output logic [3:0]  code,
   output logic        blank,
   output logic [31:0] digits,
   output logic        wrap
);

   localparam logic [PRESCALE_W-1:0] PS_MAX = PRESCALE_W'(PRESCALE - 1);

   logic [PRESCALE_W-1:0] psc;
   logic                  step;
   logic [31:0]           inc_val;
   logic [31:0]           dec_val;
   logic                  inc_co;
   logic                  dec_bo;
   logic [31:0]           ld_val;
   logic [7:0]            zhi;

   assign step = en && (psc == PS_MAX);

   always_comb begin : ripple
      logic       c;
      logic       b;
      logic [3:0] d;
      inc_val = digits;
      dec_val = digits;
      c = 1'b1;
      b = 1'b1;
      d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         d = digits[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
         if (b) begin
            if (d == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
      end
      inc_co = c;
      dec_bo = b;
   end

   always_comb begin : clamp
      logic [3:0] n;
      ld_val = 32'd0;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = load_val[4*i +: 4];
         ld_val[4*i +: 4] = (n > 4'd9) ? 4'd9 : n;
      end
   end

   // zhi[k]: digit k and every digit above it are zero
   always_comb begin : zeros
      logic z;
      zhi = 8'd0;
      z = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         z = z && (digits[4*i +: 4] == 4'd0);
         zhi[i] = z;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits <= 32'd0;
         psc    <= '0;
         wrap   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            digits <= 32'd0;
            psc    <= '0;
         end else if (load) begin
            digits <= ld_val;
            psc    <= '0;
         end else if (en) begin
            if (step) begin
               psc <= '0;
               if (up) begin
                  digits <= inc_val;
                  wrap   <= inc_co;
               end else begin
                  digits <= dec_val;
                  wrap   <= dec_bo;
               end
            end else begin
               psc <= psc + PRESCALE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code  <= 4'd0;
         blank <= 1'b0;
      end else begin
         code  <= digits[4*scan_idx +: 4];
         blank <= blank_lz && (scan_idx != 3'd0) && zhi[scan_idx];
      end
   end

endmodule

// File: tb/tb_disp_bcd_counter.sv
// Directed bench for disp_bcd_counter with PRESCALE=4.
// Read-port vectors are table driven; counting cases are hand sequenced.
module tb_disp_bcd_counter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up;
   logic        clr;
   logic        load;
   logic [31:0] load_val;
   logic        blank_lz;
   logic [2:0]  scan_idx;
   logic [3:0]  code;
   logic        blank;
   logic [31:0] digits;
   logic        wrap;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] val;
      logic [2:0]  idx;
      logic        lz;
      logic [3:0]  exp_code;
      logic        exp_blank;
   } vec_t;

   vec_t vecs[14];

   disp_bcd_counter #(
      .PRESCALE   (4),
      .PRESCALE_W (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .blank_lz (blank_lz),
      .scan_idx (scan_idx),
      .code     (code),
      .blank    (blank),
      .digits   (digits),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] v);
      load     = 1'b1;
      load_val = v;
      tick(1);
      load = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = 32'd0;
      blank_lz = 1'b0;
      scan_idx = 3'd0;

      vecs[0]  = '{32'h00000405, 3'd0, 1'b1, 4'd5, 1'b0};
      vecs[1]  = '{32'h00000405, 3'd1, 1'b1, 4'd0, 1'b0};
      vecs[2]  = '{32'h00000405, 3'd2, 1'b1, 4'd4, 1'b0};
      vecs[3]  = '{32'h00000405, 3'd3, 1'b1, 4'd0, 1'b1};
      vecs[4]  = '{32'h00000405, 3'd4, 1'b1, 4'd0, 1'b1};
      vecs[5]  = '{32'h00000405, 3'd5, 1'b1, 4'd0, 1'b1};
      vecs[6]  = '{32'h00000405, 3'd6, 1'b1, 4'd0, 1'b1};
      vecs[7]  = '{32'h00000405, 3'd7, 1'b1, 4'd0, 1'b1};
      vecs[8]  = '{32'h00000405, 3'd3, 1'b0, 4'd0, 1'b0};
      vecs[9]  = '{32'h00000405, 3'd7, 1'b0, 4'd0, 1'b0};
      vecs[10] = '{32'h00000000, 3'd0, 1'b1, 4'd0, 1'b0};
      vecs[11] = '{32'h00000000, 3'd1, 1'b1, 4'd0, 1'b1};
      vecs[12] = '{32'h00000000, 3'd7, 1'b1, 4'd0, 1'b1};
      vecs[13] = '{32'h87654321, 3'd7, 1'b1, 4'd8, 1'b0};

      #12;
      chk("reset_digits", digits, 32'd0);
      chk("reset_wrap", {31'd0, wrap}, 32'd0);
      chk("reset_code", {28'd0, code}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // count from 0 to 5, then reset asynchronously mid-cycle
      en = 1'b1;
      up = 1'b1;
      tick(20);
      chk("count_to_5", digits, 32'h00000005);
      tick(1);
      chk("code_before_rst", {28'd0, code}, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_digits", digits, 32'd0);
      chk("async_rst_code", {28'd0, code}, 32'd0);
      chk("async_rst_blank", {31'd0, blank}, 32'd0);
      chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(3);
      chk("rst_release_no_step", digits, 32'd0);
      tick(1);
      chk("rst_first_step", digits, 32'h00000001);

      // up carry ripple
      do_load(32'h00000999);
      tick(3);
      chk("carry_pre", digits, 32'h00000999);
      tick(1);
      chk("carry_ripple", digits, 32'h00001000);
      chk("carry_no_wrap", {31'd0, wrap}, 32'd0);
      do_load(32'h99999999);
      tick(4);
      chk("up_wrap_digits", digits, 32'd0);
      chk("up_wrap_pulse", {31'd0, wrap}, 32'd1);
      tick(1);
      chk("up_wrap_one_cycle", {31'd0, wrap}, 32'd0);

      // down borrow
      up = 1'b0;
      do_load(32'h00010000);
      tick(4);
      chk("borrow_ripple", digits, 32'h00009999);
      chk("borrow_no_wrap", {31'd0, wrap}, 32'd0);
      do_load(32'h00000000);
      tick(4);
      chk("down_wrap_digits", digits, 32'h99999999);
      chk("down_wrap_pulse", {31'd0, wrap}, 32'd1);
      tick(1);
      chk("down_wrap_one_cycle", {31'd0, wrap}, 32'd0);

      // clr+load on a step cycle that would otherwise wrap
      do_load(32'h00000000);
      tick(3);
      clr      = 1'b1;
      load     = 1'b1;
      load_val = 32'h12345678;
      tick(1);
      clr  = 1'b0;
      load = 1'b0;
      chk("prio_clr_digits", digits, 32'd0);
      chk("prio_no_wrap", {31'd0, wrap}, 32'd0);
      do_load(32'h0000A0F3);
      chk("load_clamp", digits, 32'h00009093);

      // enable hold keeps the prescaler phase
      up  = 1'b1;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(2);
      en = 1'b0;
      tick(10);
      chk("hold_frozen", digits, 32'd0);
      en = 1'b1;
      tick(1);
      chk("hold_no_early", digits, 32'd0);
      tick(1);
      chk("hold_step", digits, 32'h00000001);

      // read port table
      en = 1'b0;
      foreach (vecs[i]) begin
         load     = 1'b1;
         load_val = vecs[i].val;
         scan_idx = vecs[i].idx;
         blank_lz = vecs[i].lz;
         tick(1);
         load = 1'b0;
         tick(1);
         chk($sformatf("code_v%0d", i), {28'd0, code},
             {28'd0, vecs[i].exp_code});
         chk($sformatf("blank_v%0d", i), {31'd0, blank},
             {31'd0, vecs[i].exp_blank});
      end

      // code shows the pre-update value when the count changes
      do_load(32'h00000405);
      scan_idx = 3'd0;
      load     = 1'b1;
      load_val = 32'h00000009;
      tick(1);
      load = 1'b0;
      chk("code_pre_update", {28'd0, code}, 32'd5);
      tick(1);
      chk("code_post_update", {28'd0, code}, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_bcd_counter.md
Name: disp_bcd_counter

Overview:
- 8-digit decimal up/down counter that produces the digit codes for the 8-digit seven-segment scan path.
- Sits between the scan-index counter and the segment pattern decoder, and replaces the fixed 8x4 digit ROM.
- The scan index selects one digit per cycle. The block returns its 4-bit BCD code and a leading-zero blank flag.
- Counting is paced by an internal prescaler, so the display shows a live count: seconds counter, stopwatch or countdown.

Parameters:
- PRESCALE, 100000000, clk cycles per count step (1 Hz at 100 MHz); must be >= 2.
- PRESCALE_W, 27, prescaler register width; must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; low freezes prescaler and count.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- clr  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  32  eight BCD digits; [3:0] = digit 0 (rightmost).
- blank_lz  input  1  enable leading-zero blanking.
- scan_idx  input  3  digit being scanned (0..7), from the scan counter.
- code  output  4  BCD code of digit scan_idx, registered.
- blank  output  1  1 = this digit is to be displayed dark, registered.
- digits  output  32  current count, all digits, registered.
- wrap  output  1  one-cycle pulse on decimal wrap (carry or borrow out of digit 7).

Behaviour:
- Reset (rst_n low, async): digits=0, prescaler=0, code=0, blank=0, wrap=0. Release is synchronous to the next edge; no step may occur on the release edge.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - step is asserted internally in the cycle prescaler==PRESCALE-1; the prescaler returns to 0 on the same edge.
  - en=0 holds the prescaler value; it does not reset it.
- Priority per cycle: clr > load > step.
  - clr: digits=0, prescaler=0.
  - load: digits=load_val, prescaler=0. Any load_val nibble > 9 is stored as 9.
  - clr or load in a step cycle suppresses that step, and wrap stays 0.
- Step, up=1: digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit. The ripple resolves in a single cycle.
  - 99999999 -> 00000000 with wrap=1 for exactly one cycle.
- Step, up=0: digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - 00000000 -> 99999999 with wrap=1 for one cycle.
- digits output: reflects the register, updated on the same edge as the count.
- Read port:
  - code <= digits[4*scan_idx +: 4] on each edge; latency 1 cycle from scan_idx.
  - If the count changes on the same edge, code shows the pre-update value and the new value appears the next cycle.
- Blank: registered alongside code.
  - blank <= blank_lz && scan_idx != 0 && digit[scan_idx]==0 && all digits above scan_idx are 0.
  - Digit 0 is never blanked, so a count of 0 shows a single "0".
- wrap: 0 in every cycle without a wrapping step.

Test Plan:
- Reset mid-count: PRESCALE=4, en=1, count to 00000005, assert rst_n=0 asynchronously between edges -> digits, code, blank and wrap go to 0 immediately. After release, the first step occurs 4 cycles later -> 00000001.
- Up carry ripple: load 00000999, up=1, en=1 -> after PRESCALE cycles digits=00001000 and wrap=0. Load 99999999 and step -> 00000000 with wrap high for exactly 1 cycle.
- Down borrow: load 00010000, up=0 -> one step gives 00009999. Load 00000000 and step -> 99999999 with wrap pulse.
- Priority and clamping:
  - clr and load both asserted in the step cycle with load_val=0x12345678 -> digits=0, no wrap.
  - load alone with load_val=0x0000A0F3 -> digits=0x00009093.
- Read port and blanking: digits=00000405, blank_lz=1, sweep scan_idx 0..7 -> one cycle later code=5,0,4,0,0,0,0,0 and blank=0,0,0,1,1,1,1,1. With blank_lz=0, all blank=0. With digits=0 and blank_lz=1, only index 0 is unblanked.
- Enable hold: PRESCALE=4, drop en after 2 prescaler cycles for 10 cycles, then raise en -> the step occurs after 2 more enabled cycles, not 4.
